// File: rtl/nc_pkg.sv
// Shared types and constants for the NC memory cycle arbiter.
package nc_pkg;

    localparam int NC_AW = 15;
    localparam int NC_DW = 16;

    // Requester identity latched at grant time.
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } nc_state_e;

    // The NC strobe (and write enable) is high in exactly these states.
    function automatic logic is_strobe_state(input nc_state_e st);
        return (st == ST_STROBE) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/nc_grant_arb.sv
// Fixed DMA priority with a burst counter that hands the port to a waiting CPU
// after DMA_BURST consecutive DMA grants.
module nc_grant_arb #(
    parameter int DMA_BURST = 4
) (
    input  logic t_clk2,
    input  logic t_rst1,
    input  logic i_dma_req,
    input  logic i_cpu_req,
    input  logic i_grant_stb,
    output logic o_grant_dma,
    output logic o_grant_cpu
);

    localparam int BW = $clog2(DMA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(DMA_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    logic [BW-1:0] burst_cnt_q;
    logic [BW-1:0] burst_cnt_d;
    logic          sat_s;

    // Winner selection and burst counter next-state.
    always_comb begin
        sat_s       = (burst_cnt_q == BURST_MAX);
        o_grant_dma = i_dma_req & ~(sat_s & i_cpu_req);
        o_grant_cpu = i_cpu_req & ~o_grant_dma;
        burst_cnt_d = burst_cnt_q;
        if (i_grant_stb) begin
            if (o_grant_cpu) begin
                burst_cnt_d = {BW{1'b0}};
            end else if (o_grant_dma && i_cpu_req) begin
                if (sat_s) begin
                    burst_cnt_d = burst_cnt_q;
                end else begin
                    burst_cnt_d = burst_cnt_q + BURST_ONE;
                end
            end else begin
                burst_cnt_d = {BW{1'b0}};
            end
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Burst counter register.
    always_ff @(posedge t_clk2 or posedge t_rst1) begin
        if (t_rst1) begin
            burst_cnt_q <= {BW{1'b0}};
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/nc_cycle_arbiter.sv
// Sequences NC memory cycles (SETUP/STROBE/WAIT/DONE) for the DMA and CPU
// requesters; all outputs are registered and drop at once on reset.
module nc_cycle_arbiter
    import nc_pkg::*;
#(
    parameter int AW        = NC_AW,
    parameter int DW        = NC_DW,
    parameter int RD_LAT    = 2,
    parameter int DMA_BURST = 4
) (
    input  logic          t_clk2,
    input  logic          t_rst1,
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic          o_dma_ack,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_rdata,
    output logic          o_rd_err,
    output logic          o_err_sticky,
    input  logic          i_err_clr,
    output logic          o_busy,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_din,
    output logic          o_mem_we,
    output logic          o_mem_clk,
    input  logic [DW-1:0] i_mem_dout,
    input  logic          i_mem_err
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_LAT);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    nc_state_e     state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rdata_d;
    logic          rd_err_d, sticky_d, busy_d;
    logic          mem_clk_d, mem_we_d, dma_ack_d, cpu_ack_d;
    logic          grant_stb_s, grant_dma_s, grant_cpu_s, sample_s;

    assign grant_stb_s = (state_q == ST_IDLE) && (i_dma_req || i_cpu_req);

    nc_grant_arb #(.DMA_BURST(DMA_BURST)) u_grant_arb (
        .t_clk2      (t_clk2),
        .t_rst1      (t_rst1),
        .i_dma_req   (i_dma_req),
        .i_cpu_req   (i_cpu_req),
        .i_grant_stb (grant_stb_s),
        .o_grant_dma (grant_dma_s),
        .o_grant_cpu (grant_cpu_s)
    );

    // State and WAIT counter registers.
    always_ff @(posedge t_clk2 or posedge t_rst1) begin
        if (t_rst1) begin
            state_q <= ST_IDLE;
            wcnt_q  <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic; WAIT counts down from RD_LAT and exits at one.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_stb_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                state_d = ST_WAIT;
                wcnt_d  = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_ONE) begin
                    state_d = ST_DONE;
                    wcnt_d  = {CW{1'b0}};
                end else begin
                    wcnt_d  = wcnt_q - WAIT_ONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, registered below.
    always_comb begin
        sample_s  = (state_q == ST_WAIT) && (wcnt_q == WAIT_ONE);
        mem_clk_d = is_strobe_state(state_d);
        mem_we_d  = is_strobe_state(state_d) & we_q;
        busy_d    = (state_d != ST_IDLE);
        dma_ack_d = (state_d == ST_DONE) && (id_q == ID_DMA);
        cpu_ack_d = (state_d == ST_DONE) && (id_q == ID_CPU);

        id_d    = id_q;
        we_d    = we_q;
        addr_d  = o_mem_addr;
        wdata_d = o_mem_din;
        if (grant_stb_s) begin
            if (grant_dma_s) begin
                id_d    = ID_DMA;
                we_d    = i_dma_we;
                addr_d  = i_dma_addr;
                wdata_d = i_dma_wdata;
            end else if (grant_cpu_s) begin
                id_d    = ID_CPU;
                we_d    = i_cpu_we;
                addr_d  = i_cpu_addr;
                wdata_d = i_cpu_wdata;
            end else begin
                id_d    = id_q;
            end
        end else begin
            id_d = id_q;
        end

        rdata_d  = o_rdata;
        rd_err_d = o_rd_err;
        if (sample_s && !we_q) begin
            rdata_d  = i_mem_dout;
            rd_err_d = i_mem_err;
        end else if (sample_s) begin
            rd_err_d = 1'b0;
        end else begin
            rd_err_d = o_rd_err;
        end

        // A new error outranks a simultaneous clear.
        if (sample_s && !we_q && i_mem_err) begin
            sticky_d = 1'b1;
        end else if (i_err_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = o_err_sticky;
        end
    end

    // Registered outputs and request latch.
    always_ff @(posedge t_clk2 or posedge t_rst1) begin
        if (t_rst1) begin
            id_q         <= ID_CPU;
            we_q         <= 1'b0;
            o_mem_addr   <= {AW{1'b0}};
            o_mem_din    <= {DW{1'b0}};
            o_mem_clk    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_busy       <= 1'b0;
            o_dma_ack    <= 1'b0;
            o_cpu_ack    <= 1'b0;
            o_rdata      <= {DW{1'b0}};
            o_rd_err     <= 1'b0;
            o_err_sticky <= 1'b0;
        end else begin
            id_q         <= id_d;
            we_q         <= we_d;
            o_mem_addr   <= addr_d;
            o_mem_din    <= wdata_d;
            o_mem_clk    <= mem_clk_d;
            o_mem_we     <= mem_we_d;
            o_busy       <= busy_d;
            o_dma_ack    <= dma_ack_d;
            o_cpu_ack    <= cpu_ack_d;
            o_rdata      <= rdata_d;
            o_rd_err     <= rd_err_d;
            o_err_sticky <= sticky_d;
        end
    end

endmodule
